sram_arb_2p: RTL
================

Name: sram_arb_2p

Overview:
- Two-port access controller that shares one sram_sp_hse_8kx8 macro between requester 0 (bus-slave side) and requester 1 (DMA/test side).
- Arbitrates requests, then drives the macro's active-low CEN/WEN/OEN, A and D pins from flops.
- Captures Q and returns read data to the requester that issued the read.
- One access per cycle, back-to-back, no bubbles.

Parameters:
AW, 13, address width (8K words)
DW, 8, data width
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority to requester 0 with starvation guard
STARVE_LIMIT, 8, fixed mode only: consecutive cycles requester 1 may wait before a forced grant (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
m0_req  in  1  requester 0 access request; held until granted
m0_we  in  1  1 = write, 0 = read
m0_addr  in  AW  word address
m0_wdata  in  DW  write data
m0_gnt  out  1  combinational grant; transfer occurs on a clk edge with m0_req & m0_gnt
m0_rvalid  out  1  one-cycle pulse, read data valid
m0_rdata  out  DW  read data; holds its last value otherwise
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_* for requester 1
sram_cen  out  1  macro chip enable, active-low
sram_wen  out  1  macro write enable, active-low
sram_oen  out  1  macro output enable, active-low
sram_a  out  AW  macro address
sram_d  out  DW  macro write data
sram_q  in  DW  macro read data

Behaviour:
- Reset values:
  - sram_cen=1, sram_wen=1, sram_oen=1, sram_a=0, sram_d=0.
  - m*_rvalid=0, m*_rdata=0.
  - RR pointer = "last granted m1", so m0 wins the first tie.
  - Starvation counter = 0.
  - Read pipeline tags cleared.
- sram_oen: goes 0 on the first cycle after rst deasserts and stays 0.
- Grant, round-robin mode:
  - Only one requester active: it is granted.
  - Both active: grant the requester not granted last.
  - Pointer updates only on an accepted transfer.
- Grant, fixed mode:
  - m0 wins every tie.
  - Counter increments each cycle m1_req=1 and m1 is not granted; clears when m1 is granted or m1_req=0.
  - When counter == STARVE_LIMIT, m1 is granted even if m0 requests.
- m*_gnt is never 1 for both ports in the same cycle. m*_gnt is 0 when the matching req is 0 and during rst.
- Issue: on an accepted edge E, the flops load:
  - sram_cen=0, sram_wen=~we, sram_a=addr.
  - sram_d=wdata on writes; sram_d holds its previous value on reads.
- Idle edge (no grant): sram_cen=1 and sram_wen=1; sram_a and sram_d hold their values.
- Macro timing: the macro samples at E+1; Q is valid after E+1.
- Read return:
  - The block registers sram_q into the owner's m*_rdata at E+2.
  - The owner's m*_rvalid is 1 for the cycle following E+2.
  - Acceptance-to-rvalid latency is 2 clocks, fixed.
- Tag pipeline: a 2-stage tag {valid, port} travels with each read; writes carry valid=0 (no write response).
- Ordering: accesses execute in grant order. A write at E followed by a read of the same address at E+1 returns the new data.
- Back-to-back reads at E and E+1 produce rvalid on consecutive cycles, possibly to different ports.
- Address range: addresses are used as-is. 0x1FFF is legal and there is no wrap logic; the address is not incremented internally.
- Reset mid-operation:
  - rst at any edge clears the tag pipeline; pending reads produce no rvalid and rdata returns to 0.
  - sram_cen is 1 on the next cycle, so no access is issued in the cycle after reset.
- rst has priority over every other event.

Decomposition:
- Shared package sram_arb_pkg: AW/DW defaults, PRIO_RR=0 and PRIO_FIXED=1 constants, port-id constants P0=0 and P1=1, read-tag struct {valid, port}.
- One natural sub-module: sram_arb_2p_sel, the combinational grant logic plus RR pointer and starvation counter. The top holds the pin flops and the read-return pipeline.

Test Plan:
1. Basic write/read, RR mode: m0 writes 0x0001=0x12, m1 writes 0x0004=0x34; m0 reads 0x0004 and m1 reads 0x0001 -> m0_rdata=0x34 and m1_rdata=0x12, each rvalid exactly 2 clocks after acceptance.
2. Simultaneous requests, RR mode: both ports request reads for 4 consecutive cycles, starting after reset -> grants go m0, m1, m0, m1; rvalid alternates and no cycle has both gnt high.
3. Fixed mode with STARVE_LIMIT=3: m0 requests continuously while m1 holds a read of 0x0001 -> m1 is granted on its 4th waiting cycle, receives 0x12, and m0 is stalled for exactly one cycle.
4. Write-then-read hazard: m0 writes 0x1FFF=0xA5 at edge E and m1 reads 0x1FFF at E+1 -> m1_rdata=0xA5. Pin check: sram_cen low for 2 consecutive cycles, sram_wen 0 then 1.
5. Reset mid-read: m0 read of 0x0004 accepted, rst asserted 1 cycle later -> m0_rvalid never pulses, m0_rdata=0, and sram_cen=1 and sram_wen=1 on the cycle after reset.
6. Idle: no requests for 10 cycles -> sram_cen and sram_wen stay 1, sram_a and sram_d hold their last values, no rvalid.

Source files
------------

// File: rtl/sram_arb_2p_pkg.sv
// Shared types and constants for the two-port SRAM access controller.
// Holds width defaults, priority-mode ids, port ids and the read-return tag.
package sram_arb_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 8;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // Travels alongside each access; only reads carry valid=1.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/sram_arb_2p_if.sv
// Requester-side bus of the SRAM access controller.
// master: req/we/addr/wdata out, gnt/rvalid/rdata in; slave is the mirror.
interface sram_arb_2p_if
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/sram_arb_2p_sel.sv
// Grant selection for the two requesters: round-robin or fixed priority.
// Ports: clk, rst, req0_i/req1_i in; gnt0_o/gnt1_o combinational grants out.
module sram_arb_2p_sel
    import sram_arb_pkg::*;
#(
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic       last_q;
    logic       last_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       pick1;

    // pick1 only matters when both ports request: it says m1 wins the tie.
    always_comb begin
        if (PRIO_MODE == PRIO_FIXED) begin
            pick1 = (cnt_q == 8'(STARVE_LIMIT));
        end else begin
            pick1 = (last_q == P0);
        end
        gnt1_o = ~rst & req1_i & (~req0_i | pick1);
        gnt0_o = ~rst & req0_i & ~gnt1_o;
    end

    always_comb begin
        last_d = last_q;
        if (gnt0_o) begin
            last_d = P0;
        end
        if (gnt1_o) begin
            last_d = P1;
        end
        // The force grant fires at the limit, so the count never passes it.
        cnt_d = 8'd0;
        if (PRIO_MODE == PRIO_FIXED && req1_i && !gnt1_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= P1;
            cnt_q  <= 8'd0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_arb_2p.sv
// Shares one single-port SRAM macro between two requesters, one access/cycle.
// Ports: clk, rst, m0/m1 requester buses, registered sram_* pins, sram_q in.
module sram_arb_2p
    import sram_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    sram_arb_2p_if.slave  m0,
    sram_arb_2p_if.slave  m1,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic          sram_oen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    logic          g0;
    logic          g1;
    logic          acc;
    logic          we_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;

    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic          oen_q;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;

    rd_tag_t       tag1_q, tag1_d;
    rd_tag_t       tag2_q;

    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;

    sram_arb_2p_sel #(
        .PRIO_MODE    (PRIO_MODE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .clk    (clk),
        .rst    (rst),
        .req0_i (m0.req),
        .req1_i (m1.req),
        .gnt0_o (g0),
        .gnt1_o (g1)
    );

    assign m0.gnt    = g0;
    assign m1.gnt    = g1;
    assign m0.rvalid = rv0_q;
    assign m1.rvalid = rv1_q;
    assign m0.rdata  = rd0_q;
    assign m1.rdata  = rd1_q;

    assign acc     = g0 | g1;
    assign we_s    = g1 ? m1.we    : m0.we;
    assign addr_s  = g1 ? m1.addr  : m0.addr;
    assign wdata_s = g1 ? m1.wdata : m0.wdata;

    always_comb begin
        cen_d  = 1'b1;
        wen_d  = 1'b1;
        a_d    = a_q;
        d_d    = d_q;
        tag1_d = '0;
        if (acc) begin
            cen_d = 1'b0;
            wen_d = ~we_s;
            a_d   = addr_s;
            if (we_s) begin
                d_d = wdata_s;
            end
            tag1_d.valid = ~we_s;
            tag1_d.port  = g1 ? P1 : P0;
        end
        // The macro samples one edge after issue; Q is captured one edge later.
        rv0_d = tag2_q.valid & (tag2_q.port == P0);
        rv1_d = tag2_q.valid & (tag2_q.port == P1);
        rd0_d = rv0_d ? sram_q : rd0_q;
        rd1_d = rv1_d ? sram_q : rd1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cen_q  <= 1'b1;
            wen_q  <= 1'b1;
            oen_q  <= 1'b1;
            a_q    <= '0;
            d_q    <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            rd0_q  <= '0;
            rd1_q  <= '0;
        end else begin
            cen_q  <= cen_d;
            wen_q  <= wen_d;
            oen_q  <= 1'b0;
            a_q    <= a_d;
            d_q    <= d_d;
            tag1_q <= tag1_d;
            tag2_q <= tag1_q;
            rv0_q  <= rv0_d;
            rv1_q  <= rv1_d;
            rd0_q  <= rd0_d;
            rd1_q  <= rd1_d;
        end
    end

    assign sram_cen = cen_q;
    assign sram_wen = wen_q;
    assign sram_oen = oen_q;
    assign sram_a   = a_q;
    assign sram_d   = d_q;

endmodule
